// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: accepts one RV32I integer instruction (OP, OP-IMM, LUI, AUIPC),
// decodes it into ALU operator/operands, drives a registered ALU, captures the ALU result
// one cycle later and offers it to register-file writeback over a valid/ready handshake.
module alu_issue_sequencer #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inst_valid,
   output logic                  inst_ready,
   input  logic [31:0]           inst,
   input  logic [WORD_WIDTH-1:0] inst_pc,
   input  logic [WORD_WIDTH-1:0] rs1_value,
   input  logic [WORD_WIDTH-1:0] rs2_value,
   output logic [WORD_WIDTH-1:0] alu_operand1,
   output logic [WORD_WIDTH-1:0] alu_operand2,
   output logic [3:0]            alu_operator,
   input  logic [WORD_WIDTH-1:0] alu_result,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [4:0]            wb_rd,
   output logic [WORD_WIDTH-1:0] wb_data,
   output logic                  wb_write,
   output logic                  wb_illegal
);

   // ALU operator codes understood by the downstream ALU
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_SLL  = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SRA  = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;
   localparam logic [3:0] ALU_NONE = 4'd11;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {IDLE, ISSUE, RESULT, WB} state_t;

   state_t state_reg;
   state_t state_next;

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [WORD_WIDTH-1:0] imm_i;
   logic [WORD_WIDTH-1:0] imm_u;
   logic [WORD_WIDTH-1:0] shamt_reg_src;
   logic [WORD_WIDTH-1:0] shamt_imm_src;
   logic                  accept;
   logic                  dec_legal;
   logic [3:0]            dec_operator;
   logic [WORD_WIDTH-1:0] dec_operand1;
   logic [WORD_WIDTH-1:0] dec_operand2;
   logic                  unused_fields;

   assign opcode        = inst[6:0];
   assign funct3        = inst[14:12];
   assign funct7        = inst[31:25];
   assign imm_i         = {{(WORD_WIDTH-12){inst[31]}}, inst[31:20]};
   assign imm_u         = WORD_WIDTH'({inst[31:12], 12'b0});
   assign shamt_reg_src = {{(WORD_WIDTH-5){1'b0}}, rs2_value[4:0]};
   assign shamt_imm_src = {{(WORD_WIDTH-5){1'b0}}, inst[24:20]};
   // Register specifiers arrive already resolved into rs1_value/rs2_value
   assign unused_fields = ^inst[19:15];

   assign inst_ready = (state_reg == IDLE) && !reset;
   assign accept     = inst_valid && inst_ready;

   // Decode the offered instruction into operator, operands and a legality flag
   always_comb begin
      dec_legal    = 1'b1;
      dec_operator = ALU_NONE;
      dec_operand1 = rs1_value;
      dec_operand2 = rs2_value;
      case (opcode)
         OPC_OP: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_ZERO)     dec_operator = ALU_ADD;
                  else if (funct7 == F7_ALT) dec_operator = ALU_SUB;
                  else                       dec_legal    = 1'b0;
               end
               3'b001: begin
                  dec_operator = ALU_SLL;
                  dec_operand2 = shamt_reg_src;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               3'b010: begin
                  dec_operator = ALU_SLT;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               3'b011: begin
                  dec_operator = ALU_SLTU;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               3'b100: begin
                  dec_operator = ALU_XOR;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               3'b101: begin
                  dec_operand2 = shamt_reg_src;
                  if (funct7 == F7_ZERO)     dec_operator = ALU_SRL;
                  else if (funct7 == F7_ALT) dec_operator = ALU_SRA;
                  else                       dec_legal    = 1'b0;
               end
               3'b110: begin
                  dec_operator = ALU_OR;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               default: begin
                  dec_operator = ALU_AND;
                  dec_legal    = (funct7 == F7_ZERO);
               end
            endcase
         end
         OPC_OP_IMM: begin
            dec_operand2 = imm_i;
            case (funct3)
               3'b000: dec_operator = ALU_ADD;
               3'b010: dec_operator = ALU_SLT;
               3'b011: dec_operator = ALU_SLTU;
               3'b100: dec_operator = ALU_XOR;
               3'b110: dec_operator = ALU_OR;
               3'b111: dec_operator = ALU_AND;
               3'b001: begin
                  dec_operator = ALU_SLL;
                  dec_operand2 = shamt_imm_src;
                  dec_legal    = (funct7 == F7_ZERO);
               end
               default: begin
                  dec_operand2 = shamt_imm_src;
                  if (funct7 == F7_ZERO)     dec_operator = ALU_SRL;
                  else if (funct7 == F7_ALT) dec_operator = ALU_SRA;
                  else                       dec_legal    = 1'b0;
               end
            endcase
         end
         OPC_LUI: begin
            dec_operator = ALU_ADD;
            dec_operand1 = '0;
            dec_operand2 = imm_u;
         end
         OPC_AUIPC: begin
            dec_operator = ALU_ADD;
            dec_operand1 = inst_pc;
            dec_operand2 = imm_u;
         end
         default: dec_legal = 1'b0;
      endcase
      if (!dec_legal) dec_operator = ALU_NONE;
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state: illegal instructions skip the ALU and go straight to writeback
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = dec_legal ? ISSUE : WB;
         ISSUE:   state_next = RESULT;
         RESULT:  state_next = WB;
         WB:      if (wb_valid && wb_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ALU drive and writeback record; ALU operator drops to NONE after one cycle so the ALU holds
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alu_operand1 <= '0;
         alu_operand2 <= '0;
         alu_operator <= ALU_NONE;
         wb_valid     <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= '0;
         wb_write     <= 1'b0;
         wb_illegal   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  wb_rd <= inst[11:7];
                  if (dec_legal) begin
                     alu_operand1 <= dec_operand1;
                     alu_operand2 <= dec_operand2;
                     alu_operator <= dec_operator;
                  end else begin
                     wb_valid   <= 1'b1;
                     wb_data    <= '0;
                     wb_write   <= 1'b0;
                     wb_illegal <= 1'b1;
                  end
               end
            end
            ISSUE: alu_operator <= ALU_NONE;
            RESULT: begin
               wb_data    <= alu_result;
               wb_valid   <= 1'b1;
               wb_write   <= (wb_rd != 5'd0);
               wb_illegal <= 1'b0;
            end
            WB: if (wb_valid && wb_ready) wb_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
